// File: rtl/button_event_decoder.sv
// Turns the debounced button level into short/long/repeat event pulses and a wrapping mode index.
// Define BUTTON_REPEAT_EN to build the auto-repeat tick generator used while a long press is held.
module button_event_decoder #(
    parameter int unsigned C_LONG_LIMIT   = 12500000,
    parameter int unsigned C_REPEAT_LIMIT = 2500000,
    parameter int unsigned C_NUM_MODES    = 4,
    parameter int unsigned C_MODE_W       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_switch,
    output logic                o_short,
    output logic                o_long,
    output logic                o_repeat,
    output logic [C_MODE_W-1:0] o_mode,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic [23:0]         LONG_LAST = 24'(C_LONG_LIMIT - 1);
    localparam logic [C_MODE_W-1:0] MODE_LAST = C_MODE_W'(C_NUM_MODES - 1);

    if (C_LONG_LIMIT < 2 || C_LONG_LIMIT > 32'd16777215 ||
        C_REPEAT_LIMIT < 1 || C_REPEAT_LIMIT > 32'd16777215 ||
        C_NUM_MODES < 2 || C_NUM_MODES > (32'd1 << C_MODE_W)) begin : g_bad_params
        $error("button_event_decoder: parameter out of legal range");
    end

    state_t              state;
    state_t              state_nxt;
    logic [23:0]         count;
    logic [23:0]         count_nxt;
    logic                prev;
    logic                rise;
    logic                short_nxt;
    logic                long_nxt;
    logic [C_MODE_W-1:0] mode_nxt;
    logic [C_MODE_W-1:0] mode_inc;

`ifdef BUTTON_REPEAT_EN
    localparam logic [23:0] REPEAT_LAST = 24'(C_REPEAT_LIMIT - 1);
    logic repeat_nxt;
`endif

    // prev resets high so a button held through reset must be seen low before it counts
    assign rise     = i_switch && !prev;
    assign mode_inc = (o_mode == MODE_LAST) ? '0 : o_mode + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            prev    <= 1'b1;
            o_short <= 1'b0;
            o_long  <= 1'b0;
            o_mode  <= '0;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            prev    <= i_switch;
            o_short <= short_nxt;
            o_long  <= long_nxt;
            o_mode  <= mode_nxt;
            o_busy  <= (state_nxt != IDLE);
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_repeat <= 1'b0;
        end else begin
            o_repeat <= repeat_nxt;
        end
    end
`else
    assign o_repeat = 1'b0;
`endif

    // One counter serves both the press phase and the repeat phase
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESS;
                    count_nxt = 24'd1;
                end
            end
            PRESS: begin
                if (!i_switch) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (count == LONG_LAST) begin
                    state_nxt = LONG;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + 24'd1;
                end
            end
            LONG: begin
                if (!i_switch) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
`ifdef BUTTON_REPEAT_EN
                else if (count == REPEAT_LAST) begin
                    count_nxt = '0;
                end else begin
                    count_nxt = count + 24'd1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        mode_nxt  = o_mode;
`ifdef BUTTON_REPEAT_EN
        repeat_nxt = 1'b0;
`endif
        unique case (state)
            PRESS: begin
                if (!i_switch) begin
                    short_nxt = 1'b1;
                    mode_nxt  = mode_inc;
                end else if (count == LONG_LAST) begin
                    long_nxt = 1'b1;
                    mode_nxt = '0;
                end
            end
            LONG: begin
`ifdef BUTTON_REPEAT_EN
                if (i_switch && count == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    mode_nxt   = mode_inc;
                end
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed press patterns plus random presses,
// compared every cycle against a run-length model of press classification.
module tb_button_event_decoder;

    localparam int unsigned LONG   = 10;
    localparam int unsigned REPEAT = 4;
    localparam int unsigned NUM    = 3;
    localparam int unsigned MW     = 2;
`ifdef BUTTON_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          i_switch;
    logic          o_short;
    logic          o_long;
    logic          o_repeat;
    logic [MW-1:0] o_mode;
    logic          o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: press length counted as a run of high samples
    int m_mode;
    int m_n;
    bit m_active;
    bit m_long;
    bit m_last_low;
    bit e_short;
    bit e_long;
    bit e_rep;

    button_event_decoder #(
        .C_LONG_LIMIT  (LONG),
        .C_REPEAT_LIMIT(REPEAT),
        .C_NUM_MODES   (NUM),
        .C_MODE_W      (MW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_switch(i_switch),
        .o_short (o_short),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_mode  (o_mode),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".short"},  32'(o_short),  32'(e_short));
        check_eq({tag, ".long"},   32'(o_long),   32'(e_long));
        check_eq({tag, ".repeat"}, 32'(o_repeat), 32'(e_rep));
        check_eq({tag, ".mode"},   32'(o_mode),   32'(m_mode));
        check_eq({tag, ".busy"},   32'(o_busy),   32'(m_active));
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_n        = 0;
        m_active   = 1'b0;
        m_long     = 1'b0;
        m_last_low = 1'b0;
        e_short    = 1'b0;
        e_long     = 1'b0;
        e_rep      = 1'b0;
    endtask

    task automatic model_sample(input bit sw);
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (!m_active) begin
            if (sw && m_last_low) begin
                m_active = 1'b1;
                m_long   = 1'b0;
                m_n      = 1;
            end
        end else if (!sw) begin
            if (!m_long) begin
                e_short = 1'b1;
                m_mode  = (m_mode + 1) % NUM;
            end
            m_active = 1'b0;
        end else begin
            m_n++;
            if (!m_long) begin
                if (m_n == LONG) begin
                    e_long = 1'b1;
                    m_long = 1'b1;
                    m_mode = 0;
                end
            end else if (REPEAT_ON && ((m_n - LONG) % REPEAT == 0)) begin
                e_rep  = 1'b1;
                m_mode = (m_mode + 1) % NUM;
            end
        end
        m_last_low = !sw;
    endtask

    // Called at a falling edge: drive, let the DUT sample, check at the next falling edge
    task automatic step(input bit sw, input string tag);
        i_switch = sw;
        @(posedge clk);
        model_sample(sw);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic steps(input bit sw, input int n, input string tag);
        for (int i = 0; i < n; i++) step(sw, tag);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int lo;
        rst_n    = 1'b0;
        i_switch = 1'b1;
        model_reset();
        @(negedge clk);
        apply_reset("rst");

        steps(1'b1, 50, "held_thru_reset");
        step(1'b0, "rel1");
        steps(1'b1, 3, "press3");
        steps(1'b0, 3, "short1");

        for (int k = 0; k < 3; k++) begin
            steps(1'b1, 5, "short_hi");
            steps(1'b0, 5, "short_lo");
        end

        steps(1'b1, 9, "hold9");
        steps(1'b0, 3, "rel9");
        steps(1'b1, 10, "hold10");
        steps(1'b0, 3, "rel10");
        steps(1'b1, 22, "hold22");
        steps(1'b0, 3, "rel22");
        steps(1'b1, 30, "hold30");
        steps(1'b0, 3, "rel30");

        steps(1'b1, 5, "abort_hi");
        apply_reset("mid_rst");
        steps(1'b1, 3, "abort_still");
        step(1'b0, "abort_rel");
        steps(1'b1, 2, "after_abort");
        steps(1'b0, 3, "after_abort_rel");

        for (int k = 0; k < 40; k++) begin
            hi = $urandom_range(1, 26);
            lo = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) begin
                steps(1'b1, (hi + 1) / 2, "rnd_pre_rst");
                apply_reset("rnd_rst");
            end
            steps(1'b1, hi, "rnd_hi");
            steps(1'b0, lo, "rnd_lo");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
